// File: rtl/ddr_chroma_line_fetcher.sv
// ddr_chroma_line_fetcher
//
// Write-side companion of the chroma line buffer. On each accepted
// line_start for an even luma line it issues one DDR burst covering the
// chroma line (line_y/2) and streams the returned 64-bit words into the
// line buffer. Odd luma lines, and empty lines, complete without DDR
// traffic because chroma is half height and the buffered line is reused.
//
// Ports
//   clk, reset_n        : clock, synchronous active-low reset
//   line_start, line_y  : one-cycle line request and its luma line number
//   base_addr, stride   : chroma plane origin and pitch (64-bit word units)
//   width               : chroma pixels per line
//   busy, line_done     : request in flight / one-cycle completion pulse
//   ddr_addr, ddr_burstcnt, ddr_rd, ddr_busy : DDR burst read request
//   ddr_dout, ddr_dout_ready                 : DDR read return
//   buf_clear, buf_we, buf_wdata             : line buffer write interface
module ddr_chroma_line_fetcher #(
    parameter int ADDR_W    = 28,
    parameter int STRIDE_W  = 8,
    parameter int MAX_WORDS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                line_start,
    input  logic [8:0]          line_y,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [7:0]          width,
    output logic                busy,
    output logic                line_done,
    output logic [ADDR_W-1:0]   ddr_addr,
    output logic [5:0]          ddr_burstcnt,
    output logic                ddr_rd,
    input  logic                ddr_busy,
    input  logic [63:0]         ddr_dout,
    input  logic                ddr_dout_ready,
    output logic                buf_clear,
    output logic                buf_we,
    output logic [63:0]         buf_wdata
);

    localparam logic [8:0] MAX_WORDS_9 = 9'(MAX_WORDS);
    localparam logic [5:0] MAX_WORDS_6 = 6'(MAX_WORDS);

    // DRAIN is the cycle in which the final buffer write is visible; the
    // skip path also passes through it so that both paths end the same way.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RECV  = 3'd2,
        DRAIN = 3'd3,
        SKIP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [5:0]          burst_q, burst_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                clear_q, clear_d;
    logic                we_q, we_d;
    logic [63:0]         wdata_q, wdata_d;

    logic [8:0]            words_raw;
    logic [5:0]            line_words;
    logic [7+STRIDE_W:0]   line_off;
    logic [ADDR_W-1:0]     line_addr;

    // Burst geometry for the requested line, evaluated from the live inputs
    // and only captured when line_start is accepted.
    always_comb begin
        words_raw = ({1'b0, width} + 9'd7) >> 3;
        if (words_raw > MAX_WORDS_9) begin
            line_words = MAX_WORDS_6;
        end else begin
            line_words = words_raw[5:0];
        end
        line_off  = {{STRIDE_W{1'b0}}, line_y[8:1]} * {8'd0, stride};
        line_addr = base_addr + ADDR_W'(line_off);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        clear_d = 1'b0;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    addr_d  = line_addr;
                    burst_d = line_words;
                    cnt_d   = 6'd0;
                    if (line_y[0] || (line_words == 6'd0)) begin
                        state_d = SKIP;
                    end else begin
                        state_d = REQ;
                        clear_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // A beat returned in the acceptance cycle is already beat 0.
                if (!ddr_busy) begin
                    state_d = RECV;
                    if (ddr_dout_ready) begin
                        we_d    = 1'b1;
                        wdata_d = ddr_dout;
                        cnt_d   = 6'd1;
                        if (burst_q == 6'd1) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            RECV: begin
                if (ddr_dout_ready) begin
                    we_d    = 1'b1;
                    wdata_d = ddr_dout;
                    cnt_d   = cnt_q + 6'd1;
                    if ((cnt_q + 6'd1) == burst_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            SKIP:    state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            clear_q <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy         = (state_q == REQ) || (state_q == RECV) ||
                          (state_q == DRAIN) || (state_q == SKIP);
    assign line_done    = (state_q == DONE);
    assign ddr_rd       = (state_q == REQ);
    assign ddr_addr     = addr_q;
    assign ddr_burstcnt = burst_q;
    assign buf_clear    = clear_q;
    assign buf_we       = we_q;
    assign buf_wdata    = wdata_q;

endmodule

// File: tb/tb_ddr_chroma_line_fetcher.sv
module tb_ddr_chroma_line_fetcher;

    localparam int ADDR_W    = 28;
    localparam int STRIDE_W  = 8;
    localparam int MAX_WORDS = 32;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                line_start;
    logic [8:0]          line_y;
    logic [ADDR_W-1:0]   base_addr;
    logic [STRIDE_W-1:0] stride;
    logic [7:0]          width;
    logic                busy;
    logic                line_done;
    logic [ADDR_W-1:0]   ddr_addr;
    logic [5:0]          ddr_burstcnt;
    logic                ddr_rd;
    logic                ddr_busy;
    logic [63:0]         ddr_dout;
    logic                ddr_dout_ready;
    logic                buf_clear;
    logic                buf_we;
    logic [63:0]         buf_wdata;

    always #5 clk = ~clk;

    ddr_chroma_line_fetcher #(
        .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .line_start(line_start), .line_y(line_y),
        .base_addr(base_addr), .stride(stride), .width(width),
        .busy(busy), .line_done(line_done),
        .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_rd(ddr_rd),
        .ddr_busy(ddr_busy), .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready),
        .buf_clear(buf_clear), .buf_we(buf_we), .buf_wdata(buf_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int              rd_cnt = 0, clr_cnt = 0, we_cnt = 0, done_cnt = 0, unstable = 0;
    int              ls_cyc = 0, done_cyc = 0, rd_first_cyc = 0, clr_cyc = 0, last_beat_cyc = 0;
    logic            prev_rd = 1'b0;
    logic [ADDR_W-1:0] rd_addr_cap = '0;
    logic [5:0]      rd_bc_cap = '0;
    logic [63:0]     wlog [0:255];

    always @(negedge clk) begin
        prev_rd <= ddr_rd;
        if (line_start) ls_cyc <= cyc;
        if (line_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (ddr_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (!prev_rd) begin
                rd_addr_cap  <= ddr_addr;
                rd_bc_cap    <= ddr_burstcnt;
                rd_first_cyc <= cyc;
            end else if ((ddr_addr != rd_addr_cap) || (ddr_burstcnt != rd_bc_cap)) begin
                unstable <= unstable + 1;
            end
        end
        if (buf_clear) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
        end
        if (buf_we) begin
            if (we_cnt < 256) wlog[we_cnt] <= buf_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (ddr_dout_ready) last_beat_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] y, input logic [7:0] w,
                               input logic [ADDR_W-1:0] b, input logic [STRIDE_W-1:0] s);
        @(posedge clk);
        #1;
        line_y     = y;
        width      = w;
        base_addr  = b;
        stride     = s;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int gap, input logic [63:0] seed);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ddr_dout_ready = 1'b1;
            ddr_dout       = seed + 64'(k);
            repeat (gap) begin
                @(posedge clk);
                #1;
                ddr_dout_ready = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        ddr_dout_ready = 1'b0;
    endtask

    int rd0, clr0, we0, done0;

    task automatic snap();
        rd0   = rd_cnt;
        clr0  = clr_cnt;
        we0   = we_cnt;
        done0 = done_cnt;
    endtask

    initial begin
        reset_n        = 1'b0;
        line_start     = 1'b0;
        line_y         = '0;
        base_addr      = '0;
        stride         = '0;
        width          = '0;
        ddr_busy       = 1'b0;
        ddr_dout       = '0;
        ddr_dout_ready = 1'b0;
        idle(3);

        // Reset state
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(line_done), 64'd0);
        check("rst_rd",     64'(ddr_rd), 64'd0);
        check("rst_clear",  64'(buf_clear), 64'd0);
        check("rst_we",     64'(buf_we), 64'd0);
        check("rst_addr",   64'(ddr_addr), 64'd0);
        check("rst_bcnt",   64'(ddr_burstcnt), 64'd0);
        check("rst_wdata",  buf_wdata, 64'd0);
        reset_n = 1'b1;
        idle(2);

        // Even line, zero wait, back-to-back data: 0x1000 + 3*24 = 0x1048, 24 words
        snap();
        pulse_start(9'd6, 8'd192, 28'h1000, 8'd24);
        check("even_busy", 64'(busy), 64'd1);
        send_beats(24, 0, 64'hA5A5_0000_0000_1000);
        idle(4);
        check("even_addr",   64'(rd_addr_cap), 64'h1048);
        check("even_bcnt",   64'(rd_bc_cap), 64'd24);
        check("even_rd_cyc", 64'(rd_cnt - rd0), 64'd1);
        check("even_rd_lat", 64'(rd_first_cyc - ls_cyc), 64'd1);
        check("even_clr",    64'(clr_cnt - clr0), 64'd1);
        check("even_clr_lat", 64'(clr_cyc - ls_cyc), 64'd1);
        check("even_we",     64'(we_cnt - we0), 64'd24);
        for (int k = 0; k < 24; k++)
            check($sformatf("even_data%0d", k), wlog[we0 + k], 64'hA5A5_0000_0000_1000 + 64'(k));
        check("even_done",   64'(done_cnt - done0), 64'd1);
        check("even_done_lat", 64'(done_cyc - last_beat_cyc), 64'd2);
        check("even_idle_busy", 64'(busy), 64'd0);

        // Odd line: no DDR traffic, done 3 cycles after line_start
        snap();
        pulse_start(9'd7, 8'd192, 28'h1000, 8'd24);
        idle(6);
        check("odd_rd",   64'(rd_cnt - rd0), 64'd0);
        check("odd_clr",  64'(clr_cnt - clr0), 64'd0);
        check("odd_we",   64'(we_cnt - we0), 64'd0);
        check("odd_done", 64'(done_cnt - done0), 64'd1);
        check("odd_lat",  64'(done_cyc - ls_cyc), 64'd3);

        // line_start landing in the DONE cycle is ignored
        snap();
        pulse_start(9'd9, 8'd8, 28'h0, 8'd1);
        idle(1);
        line_start = 1'b1;
        idle(1);
        line_start = 1'b0;
        idle(8);
        check("done_ls_done", 64'(done_cnt - done0), 64'd1);

        // Backpressure + gaps: 0x2000 + 1*5 = 0x2005, width 13 -> 2 words
        snap();
        ddr_busy = 1'b1;
        pulse_start(9'd2, 8'd13, 28'h2000, 8'd5);
        base_addr = 28'h7777;
        stride    = 8'd9;
        width     = 8'd200;
        line_y    = 9'd3;
        repeat (5) @(posedge clk);
        #1;
        ddr_busy = 1'b0;
        send_beats(2, 2, 64'h1234_5678_9ABC_0000);
        idle(5);
        check("bp_rd_cyc",  64'(rd_cnt - rd0), 64'd6);
        check("bp_stable",  64'(unstable), 64'd0);
        check("bp_addr",    64'(rd_addr_cap), 64'h2005);
        check("bp_bcnt",    64'(rd_bc_cap), 64'd2);
        check("bp_we",      64'(we_cnt - we0), 64'd2);
        check("bp_data0",   wlog[we0],     64'h1234_5678_9ABC_0000);
        check("bp_data1",   wlog[we0 + 1], 64'h1234_5678_9ABC_0001);
        check("bp_done",    64'(done_cnt - done0), 64'd1);
        check("bp_done_lat", 64'(done_cyc - last_beat_cyc), 64'd2);

        // width=0 on an even line
        snap();
        pulse_start(9'd4, 8'd0, 28'h3000, 8'd4);
        idle(6);
        check("w0_rd",   64'(rd_cnt - rd0), 64'd0);
        check("w0_clr",  64'(clr_cnt - clr0), 64'd0);
        check("w0_done", 64'(done_cnt - done0), 64'd1);
        check("w0_lat",  64'(done_cyc - ls_cyc), 64'd3);

        // width=255 -> 32 words; 33rd spurious beat is dropped
        snap();
        pulse_start(9'd0, 8'd255, 28'h3000, 8'd40);
        send_beats(33, 0, 64'hFEDC_0000_0000_0000);
        idle(4);
        check("max_addr",  64'(rd_addr_cap), 64'h3000);
        check("max_bcnt",  64'(rd_bc_cap), 64'd32);
        check("max_we",    64'(we_cnt - we0), 64'd32);
        check("max_last",  wlog[we0 + 31], 64'hFEDC_0000_0000_001F);
        check("max_done",  64'(done_cnt - done0), 64'd1);

        // line_start during RECV is ignored
        snap();
        pulse_start(9'd8, 8'd24, 28'h100, 8'd2);
        @(posedge clk);
        #1;
        ddr_dout_ready = 1'b1;
        ddr_dout       = 64'h0BAD_F00D_0000_0000;
        @(posedge clk);
        #1;
        ddr_dout_ready = 1'b0;
        line_y         = 9'd9;
        line_start     = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        send_beats(2, 1, 64'h0BAD_F00D_0000_0001);
        idle(10);
        check("ovl_rd",    64'(rd_cnt - rd0), 64'd1);
        check("ovl_we",    64'(we_cnt - we0), 64'd3);
        check("ovl_last",  wlog[we0 + 2], 64'h0BAD_F00D_0000_0002);
        check("ovl_done",  64'(done_cnt - done0), 64'd1);

        // Reset mid-RECV
        snap();
        pulse_start(9'd10, 8'd64, 28'h400, 8'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            ddr_dout_ready = 1'b1;
            ddr_dout       = 64'h5555_0000_0000_0000 + 64'(k);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mr_busy",  64'(busy), 64'd0);
        check("mr_rd",    64'(ddr_rd), 64'd0);
        check("mr_we",    64'(buf_we), 64'd0);
        check("mr_addr",  64'(ddr_addr), 64'd0);
        check("mr_bcnt",  64'(ddr_burstcnt), 64'd0);
        check("mr_wdata", buf_wdata, 64'd0);
        reset_n = 1'b1;
        snap();
        repeat (4) @(posedge clk);
        #1;
        ddr_dout_ready = 1'b0;
        idle(4);
        check("mr_post_we",   64'(we_cnt - we0), 64'd0);
        check("mr_post_done", 64'(done_cnt - done0), 64'd0);
        check("mr_post_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
